jsv_color_sequencer: RTL

JSV_COLOR_SEQUENCER -- requirements
Module: jsv_color_sequencer

---
 rtl/jsv_color_pkg.sv | 41 ++++
 rtl/jsv_frame_prescaler.sv | 47 ++++
 rtl/jsv_color_sequencer.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/jsv_color_pkg.sv
// Shared definitions for the colour sequencer: register map, CTRL/STATUS
// bit positions, FSM state encoding and PERIOD reset value.
package jsv_color_pkg;

  // Avalon-MM word addresses
  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PERIOD = 2'd1;
  localparam logic [1:0] ADDR_COLOR  = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  // CTRL bit positions
  localparam int unsigned CTRL_RUN      = 0;
  localparam int unsigned CTRL_PINGPONG = 1;
  localparam int unsigned CTRL_ONESHOT  = 2;
  localparam int unsigned CTRL_IRQ_EN   = 3;

  // STATUS bit positions
  localparam int unsigned STAT_BUSY    = 0;
  localparam int unsigned STAT_DIR     = 1;
  localparam int unsigned STAT_WRAPPED = 2;
  localparam int unsigned STAT_CNT_LSB = 3;

  localparam int unsigned CNT_W = 16;

  localparam logic [CNT_W-1:0] PERIOD_RST = 16'd1;

  localparam logic [2:0] COLOR_MAX = 3'd7;
  localparam logic [2:0] COLOR_MIN = 3'd0;

  typedef enum logic [1:0] {
    ST_STOP = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2
  } seq_state_e;

  // A programmed period of zero behaves as one frame per step.
  function automatic logic [CNT_W-1:0] eff_period(input logic [CNT_W-1:0] period);
    return (period == '0) ? 16'd1 : period;
  endfunction

endpackage

// File: rtl/jsv_frame_prescaler.sv
// Frame prescaler: counts frame_done pulses while enabled and emits a
// one-cycle step pulse when the count reaches eff_period-1.
module jsv_frame_prescaler
  import jsv_color_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic             frame_done_i,
  input  logic [CNT_W-1:0] period_i,
  output logic [CNT_W-1:0] frame_cnt_o,
  output logic             step_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             terminal;

  // Terminal compare and step pulse; a clear in the same cycle cancels the step.
  always_comb begin
    terminal = (cnt_q >= (eff_period(period_i) - 16'd1));
    step_o   = en_i && frame_done_i && !clr_i && terminal;
  end

  // Next count: held at zero while disabled or cleared, wraps at terminal.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || !en_i) begin
      cnt_d = '0;
    end else if (frame_done_i) begin
      cnt_d = terminal ? '0 : cnt_q + 16'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign frame_cnt_o = cnt_q;

endmodule

// File: rtl/jsv_color_sequencer.sv
// Colour-scheme sequencer with an Avalon-MM register file. Steps color_sel
// up/down every PERIOD frames, with wrap, ping-pong and one-shot modes.
// Optional feature macro: JSV_COLOR_SEQ_IRQ_EN adds wrap_irq and CTRL bit3.
module jsv_color_sequencer
  import jsv_color_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        frame_done,
  output logic [2:0]  color_sel
`ifdef JSV_COLOR_SEQ_IRQ_EN
  ,
  output logic        wrap_irq
`endif
);

  seq_state_e state_q, state_d;

  logic             run_q, run_d;
  logic             pingpong_q, pingpong_d;
  logic             oneshot_q, oneshot_d;
  logic             irq_en;
  logic [CNT_W-1:0] period_q, period_d;
  logic [2:0]       pending_q, pending_d;
  logic             pend_vld_q, pend_vld_d;
  logic [2:0]       color_q, color_d;
  logic             wrapped_q, wrapped_d;

  logic             wr_en;
  logic             ctrl_wr, period_wr, color_wr, status_wr;
  logic             stop_wr;
  logic             pend_apply;
  logic             pre_clr;
  logic             step;
  logic [CNT_W-1:0] frame_cnt;

  logic [2:0]       step_color;
  logic             wrap_set;
  logic             oneshot_end;
  logic             busy;
  logic             dir_down;

  logic             unused_wd;

  assign unused_wd = ^writedata[31:16];

  // Bus write decode.
  always_comb begin
    wr_en     = chipselect && !write_n;
    ctrl_wr   = wr_en && (address == ADDR_CTRL);
    period_wr = wr_en && (address == ADDR_PERIOD);
    color_wr  = wr_en && (address == ADDR_COLOR);
    status_wr = wr_en && (address == ADDR_STATUS);
    stop_wr   = ctrl_wr && !writedata[CTRL_RUN];
    // A pending colour lands on the next frame boundary unless a fresh
    // COLOR write coincides with it, which then applies directly.
    pend_apply = frame_done && pend_vld_q && !color_wr;
    pre_clr    = period_wr || (color_wr && frame_done) || pend_apply || stop_wr;
  end

  jsv_frame_prescaler u_prescaler (
    .clk          (clk),
    .rst_n        (reset_n),
    .en_i         (state_q != ST_STOP),
    .clr_i        (pre_clr),
    .frame_done_i (frame_done),
    .period_i     (period_q),
    .frame_cnt_o  (frame_cnt),
    .step_o       (step)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_STOP;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state plus the colour that a step would produce at the ends.
  always_comb begin
    state_d     = state_q;
    step_color  = color_q;
    wrap_set    = 1'b0;
    oneshot_end = 1'b0;
    if (step) begin
      case (state_q)
        ST_UP: begin
          if (color_q == COLOR_MAX) begin
            if (oneshot_q) begin
              oneshot_end = 1'b1;
              state_d     = ST_STOP;
            end else if (pingpong_q) begin
              step_color = COLOR_MAX - 3'd1;
              state_d    = ST_DOWN;
              wrap_set   = 1'b1;
            end else begin
              step_color = COLOR_MIN;
              wrap_set   = 1'b1;
            end
          end else begin
            step_color = color_q + 3'd1;
          end
        end
        ST_DOWN: begin
          if (color_q == COLOR_MIN) begin
            if (oneshot_q) begin
              oneshot_end = 1'b1;
              state_d     = ST_STOP;
            end else if (pingpong_q) begin
              step_color = COLOR_MIN + 3'd1;
              state_d    = ST_UP;
              wrap_set   = 1'b1;
            end else begin
              step_color = COLOR_MAX;
              wrap_set   = 1'b1;
            end
          end else begin
            step_color = color_q - 3'd1;
          end
        end
        default: ;
      endcase
    end
    if (ctrl_wr) begin
      if (!writedata[CTRL_RUN]) begin
        state_d = ST_STOP;
      end else if (state_q == ST_STOP) begin
        state_d = ST_UP;
      end
    end
  end

  // FSM outputs.
  always_comb begin
    busy     = (state_q != ST_STOP);
    dir_down = (state_q == ST_DOWN);
  end

  // Register-file next values; a one-shot end clears RUN even over a CTRL write.
  always_comb begin
    run_d      = run_q;
    pingpong_d = pingpong_q;
    oneshot_d  = oneshot_q;
    period_d   = period_q;
    pending_d  = pending_q;
    pend_vld_d = pend_vld_q;
    color_d    = color_q;
    if (ctrl_wr) begin
      run_d      = writedata[CTRL_RUN];
      pingpong_d = writedata[CTRL_PINGPONG];
      oneshot_d  = writedata[CTRL_ONESHOT];
    end
    if (oneshot_end) begin
      run_d = 1'b0;
    end
    if (period_wr) begin
      period_d = writedata[CNT_W-1:0];
    end
    if (color_wr) begin
      pending_d  = writedata[2:0];
      pend_vld_d = !frame_done;
    end else if (pend_apply) begin
      pend_vld_d = 1'b0;
    end
    if (color_wr && frame_done) begin
      color_d = writedata[2:0];
    end else if (pend_apply) begin
      color_d = pending_q;
    end else if (step) begin
      color_d = step_color;
    end
    // Set has priority over a software clear in the same cycle.
    wrapped_d = wrap_set || (wrapped_q && !(status_wr && writedata[STAT_WRAPPED]));
  end

  // Register file state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_q      <= 1'b0;
      pingpong_q <= 1'b0;
      oneshot_q  <= 1'b0;
      period_q   <= PERIOD_RST;
      pending_q  <= '0;
      pend_vld_q <= 1'b0;
      color_q    <= '0;
      wrapped_q  <= 1'b0;
    end else begin
      run_q      <= run_d;
      pingpong_q <= pingpong_d;
      oneshot_q  <= oneshot_d;
      period_q   <= period_d;
      pending_q  <= pending_d;
      pend_vld_q <= pend_vld_d;
      color_q    <= color_d;
      wrapped_q  <= wrapped_d;
    end
  end

`ifdef JSV_COLOR_SEQ_IRQ_EN
  // IRQ enable bit in CTRL.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_en <= 1'b0;
    end else if (ctrl_wr) begin
      irq_en <= writedata[CTRL_IRQ_EN];
    end
  end

  assign wrap_irq = wrapped_q && irq_en;
`else
  assign irq_en = 1'b0;
`endif

  assign color_sel = color_q;

  // Zero-wait-state read mux; reads have no side effects.
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_CTRL: begin
        readdata[CTRL_RUN]      = run_q;
        readdata[CTRL_PINGPONG] = pingpong_q;
        readdata[CTRL_ONESHOT]  = oneshot_q;
        readdata[CTRL_IRQ_EN]   = irq_en;
      end
      ADDR_PERIOD: readdata[CNT_W-1:0] = period_q;
      ADDR_COLOR:  readdata[2:0]       = pending_q;
      ADDR_STATUS: begin
        readdata[STAT_BUSY]                 = busy;
        readdata[STAT_DIR]                  = dir_down;
        readdata[STAT_WRAPPED]              = wrapped_q;
        readdata[STAT_CNT_LSB +: CNT_W]     = frame_cnt;
      end
      default: ;
    endcase
  end

endmodule
